// File: rtl/counter_pkg.sv
// Shared definitions for the timing-datapath counters (up-counter and
// down-counter timer): default width and the timer state encoding.
package counter_pkg;

  // Default counter width shared by the up- and down-counters.
  localparam int COUNTER_WIDTH = 4;

  // Timer states, held in a 2-bit encoded register.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_EXPIRE = 2'b10
  } state_t;

  // A load of zero has nothing to count down, so it expires immediately.
  function automatic state_t load_state(input logic nonzero);
    return nonzero ? ST_RUN : ST_EXPIRE;
  endfunction

endpackage

// File: rtl/down_counter_timer.sv
// Loadable down-counter / timer. A load event copies load_val into count
// and starts the run; count decrements once per clock and out pulses for
// exactly one cycle when it reaches zero. With reload held high at expiry
// the timer restarts from load_val, giving a period of load_val+1 cycles.
module down_counter_timer
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             reload,
  output logic [WIDTH-1:0] count,
  output logic             out,
  output logic             busy
);

  state_t           state;
  logic             load_nonzero;
  logic [WIDTH-1:0] one;

  assign load_nonzero = (load_val != '0);
  assign one          = {{(WIDTH-1){1'b0}}, 1'b1};

  // State and count register: start wins over everything, otherwise the
  // current state decides between hold, decrement, expiry and reload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      count <= '0;
    end else if (start) begin
      state <= load_state(load_nonzero);
      count <= load_val;
    end else begin
      case (state)
        ST_IDLE: begin
          // Hold: count keeps its last value (0 after an expiry).
        end
        ST_RUN: begin
          if (!pause) begin
            // count <= 1 also covers a zero count defensively so the
            // counter can never wrap to all-ones.
            if (count > one) begin
              count <= count - one;
            end else begin
              count <= '0;
              state <= ST_EXPIRE;
            end
          end
        end
        ST_EXPIRE: begin
          // Pause is ignored here: the pulse lasts exactly one cycle.
          if (reload) begin
            state <= load_state(load_nonzero);
            count <= load_val;
          end else begin
            state <= ST_IDLE;
            count <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          count <= '0;
        end
      endcase
    end
  end

  // Outputs decoded purely from the state register.
  assign out  = (state == ST_EXPIRE);
  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: directed scenarios plus a
// randomized run, all compared every cycle against an output-level model.
module tb_down_counter_timer;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] load_val;
  logic         start;
  logic         pause;
  logic         reload;
  logic [W-1:0] count;
  logic         out;
  logic         busy;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model kept in terms of the visible outputs only.
  int m_count;
  bit m_out;
  bit m_busy;

  down_counter_timer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .load_val (load_val),
    .start    (start),
    .pause    (pause),
    .reload   (reload),
    .count    (count),
    .out      (out),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_miss++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_out   = 1'b0;
    m_busy  = 1'b0;
  endtask

  // One rising edge of the timer, described by its rules:
  // a load restarts from load_val (zero expires at once); an expiry cycle
  // either reloads or falls idle; a running, unpaused count steps down and
  // pulses on reaching zero.
  task automatic model_edge();
    if (start) begin
      m_count = int'(load_val);
      m_out   = (load_val == 0);
      m_busy  = 1'b1;
    end else if (m_out) begin
      if (reload) begin
        m_count = int'(load_val);
        m_out   = (load_val == 0);
        m_busy  = 1'b1;
      end else begin
        m_count = 0;
        m_out   = 1'b0;
        m_busy  = 1'b0;
      end
    end else if (m_busy && !pause) begin
      m_count = m_count - 1;
      m_out   = (m_count == 0);
    end
  endtask

  // Apply one set of inputs across one rising edge and compare all outputs.
  task automatic step(input bit s, input bit p, input bit r, input logic [W-1:0] lv);
    start    = s;
    pause    = p;
    reload   = r;
    load_val = lv;
    @(posedge clk);
    model_edge();
    #1;
    $display("t=%0t start=%0b pause=%0b reload=%0b load=%0d -> count=%0d out=%0b busy=%0b",
             $time, s, p, r, lv, count, out, busy);
    check("count", int'(count), m_count);
    check("out", int'(out), int'(m_out));
    check("busy", int'(busy), int'(m_busy));
  endtask

  // Step with no load until out is seen; returns the edges taken.
  task automatic run_to_out(input bit r, input logic [W-1:0] lv, output int edges);
    edges = 0;
    do begin
      step(1'b0, 1'b0, r, lv);
      edges++;
    end while (!out && edges < 40);
  endtask

  int e;
  int tot;

  initial begin
    rst = 1'b0; start = 1'b0; pause = 1'b0; reload = 1'b0; load_val = '0;
    model_reset();
    #2;
    check("reset_count", int'(count), 0);
    check("reset_out", int'(out), 0);
    check("reset_busy", int'(busy), 0);
    #10 rst = 1'b1;  // released between edges

    // One-shot, load 4: out on the 4th edge after the load edge.
    step(1'b1, 1'b0, 1'b0, 4'd4);
    check("oneshot_load", int'(count), 4);
    run_to_out(1'b0, 4'd4, e);
    check("oneshot_latency", e, 4);
    step(1'b0, 1'b0, 1'b0, 4'd4);
    check("oneshot_idle_busy", int'(busy), 0);

    // Auto-reload, load 3: period of 4 cycles.
    step(1'b1, 1'b0, 1'b1, 4'd3);
    run_to_out(1'b1, 4'd3, e);
    run_to_out(1'b1, 4'd3, e);
    check("reload_period", e, 4);
    check("reload_busy", int'(busy), 1);
    step(1'b0, 1'b0, 1'b0, 4'd3);

    // Pause three cycles at count 3: expiry delayed by exactly 3.
    step(1'b1, 1'b0, 1'b0, 4'd5);
    step(1'b0, 1'b0, 1'b0, 4'd5);
    step(1'b0, 1'b0, 1'b0, 4'd5);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 4'd5);
      check("pause_hold", int'(count), 3);
    end
    run_to_out(1'b0, 4'd5, e);
    check("pause_latency", 5 + e, 5 + 3);
    step(1'b0, 1'b0, 1'b0, 4'd5);

    // Load of zero expires on the next edge.
    step(1'b1, 1'b0, 1'b0, 4'd0);
    check("zero_out", int'(out), 1);
    step(1'b0, 1'b0, 1'b0, 4'd0);
    check("zero_after", int'(out), 0);

    // Full-scale load: 15 decrements, no wrap.
    step(1'b1, 1'b0, 1'b0, 4'd15);
    run_to_out(1'b0, 4'd15, e);
    check("max_latency", e, 15);

    // Start during the expiry cycle restarts instead of idling.
    step(1'b1, 1'b0, 1'b0, 4'd6);
    check("expire_restart_count", int'(count), 6);
    check("expire_restart_busy", int'(busy), 1);

    // Restart at count 2 with 9: interrupted run gives no pulse.
    tot = 0;
    while (count != 4'd2 && tot < 20) begin
      step(1'b0, 1'b0, 1'b0, 4'd6);
      tot++;
    end
    check("restart_reach2", int'(count), 2);
    step(1'b1, 1'b0, 1'b0, 4'd9);
    check("restart_count", int'(count), 9);
    run_to_out(1'b0, 4'd9, e);
    check("restart_latency", e, 9);
    step(1'b0, 1'b0, 1'b0, 4'd9);

    // Asynchronous reset mid-run at count 7, between edges.
    step(1'b1, 1'b0, 1'b0, 4'd7);
    start = 1'b0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("async_count", int'(count), 0);
    check("async_out", int'(out), 0);
    check("async_busy", int'(busy), 0);
    #3 rst = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 4'd7);

    // Reset during the expiry cycle drops out immediately.
    step(1'b1, 1'b0, 1'b1, 4'd0);
    start = 1'b0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("async_expire_out", int'(out), 0);
    #3 rst = 1'b1;
    step(1'b0, 1'b0, 1'b1, 4'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] lv;
      lv = ($urandom_range(0, 5) == 0) ? 4'd0 : W'($urandom_range(0, 15));
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 1) == 0), lv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
